sample_fifo: RTL

SAMPLE_FIFO -- requirements
Module: sample_fifo

---
 rtl/fir_engine_pkg.sv | 12 +
 rtl/sample_fifo_mem.sv | 35 +++
 rtl/sample_fifo.sv | 132 +++++++++++++
 3 files changed

// File: rtl/fir_engine_pkg.sv
// Shared constants and types for the FIR engine datapath.
//   FifoDepth   : default number of entries in the output sample FIFO
//   SampleWidth : default width of a FIR output sample (two's complement)
//   sample_t    : signed sample type used across the FIR engine
package fir_engine_pkg;

    localparam int FifoDepth   = 8;
    localparam int SampleWidth = 12;

    typedef logic signed [SampleWidth-1:0] sample_t;

endpackage

// File: rtl/sample_fifo_mem.sv
// Register-array storage for sample_fifo. Contents are not reset; the FIFO
// control logic guarantees no entry is read before it has been written.
// Ports:
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : asynchronous read address
//   rd_data  : asynchronous read data
module sample_fifo_mem
    import fir_engine_pkg::*;
#(
    parameter int DataWidth = SampleWidth,
    parameter int Depth     = FifoDepth,
    parameter int AddrWidth = $clog2(Depth)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [AddrWidth-1:0] wr_addr,
    input  logic [DataWidth-1:0] wr_data,
    input  logic [AddrWidth-1:0] rd_addr,
    output logic [DataWidth-1:0] rd_data
);

    logic [DataWidth-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sample_fifo.sv
// Sample FIFO between the FIR engine and the I2S/DAC path.
// Writes are FIR-done strobes; reads are one-cycle requests answered one
// cycle later with a registered sample and an rdValid pulse. An empty read
// holds the previous sample and sets the sticky underflow flag; a write into
// a full FIFO (without a same-cycle read) is dropped and sets overflow.
// Optional macro SAMPLE_FIFO_STATS_EN adds saturating 8-bit event counters;
// without it ovfCount/unfCount are tied to zero.
// Ports:
//   clk, reset (async, active low)
//   wrData/wrValid      : sample input
//   rdReq               : read request
//   flush               : synchronous clear of pointers, level and rdData
//   rdData/rdValid      : registered sample output
//   level               : occupancy 0..Depth
//   overflow/underflow  : sticky error flags (cleared by reset only)
//   ovfCount/unfCount   : saturating event counters
module sample_fifo
    import fir_engine_pkg::*;
#(
    parameter int DataWidth = SampleWidth,
    parameter int Depth     = FifoDepth
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DataWidth-1:0]     wrData,
    input  logic                     wrValid,
    input  logic                     rdReq,
    input  logic                     flush,
    output logic [DataWidth-1:0]     rdData,
    output logic                     rdValid,
    output logic [$clog2(Depth):0]   level,
    output logic                     overflow,
    output logic                     underflow,
    output logic [7:0]               ovfCount,
    output logic [7:0]               unfCount
);

    localparam int PtrW = $clog2(Depth);
    localparam int LvlW = PtrW + 1;
    localparam logic [LvlW-1:0] FullLvl = LvlW'(Depth);

    logic [PtrW-1:0]      wr_ptr, rd_ptr;
    logic [DataWidth-1:0] head_data;
    logic                 is_full, is_empty;
    logic                 wr_en, rd_en, ovf_evt, unf_evt;

    assign is_full  = (level == FullLvl);
    assign is_empty = (level == '0);

    // A same-cycle read frees a slot, so a full FIFO still accepts the write.
    // At level 0 the read underflows but the write is still stored.
    assign wr_en   = wrValid && !flush && (!is_full || rdReq);
    assign rd_en   = rdReq && !flush && !is_empty;
    assign ovf_evt = wrValid && !flush && is_full && !rdReq;
    assign unf_evt = rdReq && !flush && is_empty;

    sample_fifo_mem #(
        .DataWidth (DataWidth),
        .Depth     (Depth),
        .AddrWidth (PtrW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wrData),
        .rd_addr (rd_ptr),
        .rd_data (head_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            rdData    <= '0;
            rdValid   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            rdData  <= '0;
            rdValid <= 1'b0;
        end else begin
            rdValid <= rdReq;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PtrW'(1);
                rdData <= head_data;
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + LvlW'(1);
                2'b01:   level <= level - LvlW'(1);
                default: level <= level;
            endcase
            if (ovf_evt) begin
                overflow <= 1'b1;
            end
            if (unf_evt) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef SAMPLE_FIFO_STATS_EN
    logic [7:0] ovf_cnt, unf_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_cnt <= '0;
            unf_cnt <= '0;
        end else begin
            if (ovf_evt && ovf_cnt != 8'hFF) begin
                ovf_cnt <= ovf_cnt + 8'd1;
            end
            if (unf_evt && unf_cnt != 8'hFF) begin
                unf_cnt <= unf_cnt + 8'd1;
            end
        end
    end

    assign ovfCount = ovf_cnt;
    assign unfCount = unf_cnt;
`else
    assign ovfCount = '0;
    assign unfCount = '0;
`endif

endmodule
